// File: rtl/limbus_sys_acortex_mm2st_fifo.sv
// Avalon-MM to Avalon-ST FIFO with CSR level readback and an output register.
// Define ACORTEX_MM2ST_FIFO_STATS_EN to build the watermark/overflow statistics.
module limbus_sys_acortex_mm2st_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 128,
    parameter int AF_MARGIN = 3,
    parameter int BYTE_SWAP = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        avalonmm_slave_address,
    input  logic              avalonmm_slave_write,
    input  logic              avalonmm_slave_read,
    input  logic [DATA_W-1:0] avalonmm_slave_writedata,
    output logic [DATA_W-1:0] avalonmm_slave_readdata,
    output logic              avalonmm_slave_waitrequest,
    output logic [DATA_W-1:0] avalonst_source_data,
    output logic              avalonst_source_valid,
    input  logic              avalonst_source_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic [LW-1:0]     level;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] swapped;
    logic [DATA_W-1:0] csr_mux;
    logic [DATA_W-1:0] stats_word;
    logic              near_full;
    logic              push;
    logic              load;
    logic              pop;
    logic              flush;

    assign level     = count + LW'(valid_q);
    assign near_full = level >= LW'(DEPTH - AF_MARGIN);

    assign avalonmm_slave_waitrequest = avalonmm_slave_write
                                      & (avalonmm_slave_address == 2'd0)
                                      & near_full;

    assign push  = avalonmm_slave_write & (avalonmm_slave_address == 2'd0)
                 & ~near_full;
    assign flush = avalonmm_slave_write & (avalonmm_slave_address == 2'd2)
                 & avalonmm_slave_writedata[0];
    assign load  = (~valid_q | avalonst_source_ready) & (count != '0);
    assign pop   = valid_q & avalonst_source_ready;

    assign avalonst_source_data  = data_q;
    assign avalonst_source_valid = valid_q;

    always_comb begin
        swapped = avalonmm_slave_writedata;
        if (BYTE_SWAP != 0) begin
            for (int i = 0; i < NB; i++) begin
                swapped[8*i +: 8] = avalonmm_slave_writedata[8*(NB-1-i) +: 8];
            end
        end
    end

    // Storage is intentionally not reset; pointers/count gate visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= swapped;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, load})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= mem[rd_ptr];
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef ACORTEX_MM2ST_FIFO_STATS_EN
    logic [LW-1:0]           watermark;
    logic [15:0]             overflow;
    logic [DATA_W+LW+15:0]   stats_wide;
    logic                    stats_clr;

    assign stats_clr  = avalonmm_slave_write & (avalonmm_slave_address == 2'd3);
    assign stats_wide = {{DATA_W{1'b0}}, overflow, watermark};
    assign stats_word = stats_wide[DATA_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            watermark <= '0;
            overflow  <= '0;
        end else if (stats_clr) begin
            watermark <= '0;
            overflow  <= '0;
        end else begin
            if (level > watermark) begin
                watermark <= level;
            end
            if (avalonmm_slave_waitrequest && overflow != 16'hFFFF) begin
                overflow <= overflow + 16'd1;
            end
        end
    end
`else
    assign stats_word = '0;
`endif

    always_comb begin
        csr_mux = '0;
        unique case (avalonmm_slave_address)
            2'd1:    csr_mux[LW-1:0] = level;
            2'd3:    csr_mux = stats_word;
            default: csr_mux = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            avalonmm_slave_readdata <= '0;
        end else if (avalonmm_slave_read) begin
            avalonmm_slave_readdata <= csr_mux;
        end
    end

endmodule

// File: doc/limbus_sys_acortex_mm2st_fifo.md
LIMBUS_SYS_ACORTEX_MM2ST_FIFO -- requirements
Module: limbus_sys_acortex_mm2st_fifo

Interface
REQ-001 Parameter: DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter: DEPTH, default 128, memory words; SHALL be a power of 2, minimum 4.
REQ-003 Parameter: AF_MARGIN, default 3, almost-full margin in words; SHALL be in 1..DEPTH-1.
REQ-004 Parameter: BYTE_SWAP, default 1; 1 reverses byte order on write, 0 passes data through unchanged.
REQ-005 Port: clock  in  1  single clock for all logic.
REQ-006 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-007 Port: avalonmm_slave_address  in  2  0=data, 1=level CSR, 2=control, 3=stats.
REQ-008 Port: avalonmm_slave_write / avalonmm_slave_read  in  1 each  Avalon-MM strobes.
REQ-009 Port: avalonmm_slave_writedata  in  DATA_W  write data.
REQ-010 Port: avalonmm_slave_readdata  out  DATA_W  CSR read data, fixed read latency 1.
REQ-011 Port: avalonmm_slave_waitrequest  out  1  stall.
REQ-012 Port: avalonst_source_data  out  DATA_W; avalonst_source_valid  out  1; avalonst_source_ready  in  1.

Function
REQ-013 Level L SHALL equal the words in memory plus 1 when the output register holds valid data; L is clog2(DEPTH)+1 bits wide, maximum DEPTH+1.
REQ-014 waitrequest SHALL equal write & (address==0) & (L >= DEPTH-AF_MARGIN), where L is the registered level; it is 0 for all other accesses.
REQ-015 A data write (address 0, write, no waitrequest) SHALL push the word into memory in the same cycle, with bytes reversed when BYTE_SWAP=1 (byte 0 becomes byte DATA_W/8-1).
REQ-016 The output register SHALL load the memory head whenever the register is empty, or is valid and ready=1, and memory is non-empty.
REQ-017 Latency: a word written in cycle N into an empty FIFO SHALL appear with source_valid=1 in cycle N+2.
REQ-018 While valid=1 and ready=0, source_data and source_valid SHALL hold stable.
REQ-019 A transfer occurs on valid & ready; with continuous ready=1 and a non-empty memory, one word SHALL be delivered per cycle with no bubbles.
REQ-020 Words SHALL be delivered in write order with no loss or duplication.
REQ-021 A simultaneous push and pop SHALL leave L unchanged; push to a full memory SHALL NOT occur (blocked by REQ-014).
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 A read of address 1 SHALL return L zero-extended; a read of address 0 or 2 SHALL return 0.
REQ-024 A write to address 2 with bit0=1 (flush) SHALL in the next cycle give valid=0, L=0, pointers equal; a flush overrides a same-cycle pop.
REQ-025 Writes to addresses 1 and 3 SHALL be ignored unless REQ-033 applies.

Reset
REQ-026 On reset_n=0, the following SHALL clear immediately, regardless of clock: source_valid=0, source_data=0, L=0, pointers=0, readdata=0, high-watermark=0.
REQ-027 Memory contents SHALL NOT be reset; no stale word SHALL become visible after reset.
REQ-028 Reset applied mid-transfer SHALL discard all buffered words.

Configuration
REQ-029 Macro ACORTEX_MM2ST_FIFO_STATS_EN SHALL gate the statistics logic.
REQ-030 With the macro defined, a high-watermark register SHALL track max(L) since reset or the last clear.
REQ-031 With the macro defined, a read of address 3 SHALL return {overflow_attempts[15:0], watermark} packed from bit 0 up, zero-extended.
REQ-032 overflow_attempts SHALL count cycles in which waitrequest=1 and saturate at 0xFFFF.
REQ-033 With the macro defined, a write to address 3 SHALL clear both statistics.
REQ-034 Without the macro, a read of address 3 SHALL return 0 and no statistics registers SHALL be synthesised.

Verification (DATA_W=32, DEPTH=8, AF_MARGIN=3, BYTE_SWAP=1)
REQ-035 Write 0x11223344 to address 0 at cycle N with ready=1 -> source_valid=1 with data 0x44332211 at N+2 for exactly one cycle.
REQ-036 With ready=0, write 6 words back-to-back -> 5 accepted, waitrequest=1 on the 6th; a read of address 1 returns 5; raising ready releases the 6th write.
REQ-037 Write 8 words while randomly toggling ready -> all 8 delivered in order, data stable during every valid & !ready cycle.
REQ-038 Buffer 4 words, then write 0x1 to address 2 while ready=1 -> valid=0 next cycle, address 1 reads 0.
REQ-039 With L=3 and valid=1, pulse reset_n low mid-cycle -> valid=0 and L=0 immediately; later writes are delivered normally.
REQ-040 With STATS_EN, after REQ-036 -> address 3 reads watermark=5 and overflow_attempts >= 1; a write to address 3 clears both to 0.
